// File: rtl/ps2_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ps2_pkg
// Purpose  : Shared constants and FSM encoding for the PS/2 packet receiver.
// Revision : 1.0 - initial release
// ============================================================================
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;

    localparam logic [3:0] BIT_START    = 4'd0;
    localparam logic [3:0] BIT_DATA_LSB = 4'd1;
    localparam logic [3:0] BIT_PARITY   = 4'd9;
    localparam logic [3:0] BIT_STOP     = 4'd10;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ps2_state_t;

endpackage : ps2_pkg
`default_nettype wire

// File: rtl/ps2_line_filter.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_filter
// Purpose  : 2-flop synchroniser plus debounce; output idles high.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_line_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_pin,
    output logic o_line
);

    localparam int CNT_W = $clog2(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             line_q;
    logic [CNT_W-1:0] cnt_q;

    // The counter tracks how many consecutive samples disagree with the output.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            line_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= i_pin;
            sync2_q <= sync1_q;
            if (sync2_q == line_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                line_q <= sync2_q;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign o_line = line_q;

endmodule : ps2_line_filter
`default_nettype wire

// File: rtl/ps2_packet_rx.sv
`default_nettype none
// ============================================================================
// Module   : ps2_packet_rx
// Purpose  : PS/2 device-to-host receiver assembling FRAMES bytes per packet.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_packet_rx
    import ps2_pkg::*;
#(
    parameter int FRAMES         = 4,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CHECK_PARITY   = 1,
    parameter int ALIGN_BIT3     = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic                  i_PS2Clk,
    input  logic                  i_PS2Data,
    output logic [8*FRAMES-1:0]   o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_frame_err,
    output logic                  o_timeout,
    output logic                  o_overrun
);

    localparam int IDX_W  = $clog2(PS2_FRAME_BITS);
    localparam int FIDX_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
    localparam int TO_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FIDX_W-1:0] LAST_FRAME = FIDX_W'(FRAMES - 1);
    localparam logic [TO_W-1:0]   TO_LIMIT   = TO_W'(TIMEOUT_CYCLES);

    logic w_ps2clk;
    logic w_ps2dat;

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_pin     (i_PS2Clk),
        .o_line    (w_ps2clk)
    );

    ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_pin     (i_PS2Data),
        .o_line    (w_ps2dat)
    );

    ps2_state_t           state_q,     state_d;
    logic [IDX_W-1:0]     bit_idx_q,   bit_idx_d;
    logic [7:0]           byte_q,      byte_d;
    logic                 parity_q,    parity_d;
    logic [FIDX_W-1:0]    fidx_q,      fidx_d;
    logic [8*FRAMES-1:0]  pkt_q,       pkt_d;
    logic [TO_W-1:0]      to_cnt_q,    to_cnt_d;
    logic [8*FRAMES-1:0]  data_q,      data_d;
    logic                 valid_q,     valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 timeout_q,   timeout_d;
    logic                 overrun_q,   overrun_d;
    logic                 ps2clk_prev_q;

    logic                 w_fall;
    logic                 w_good;
    logic                 w_complete;
    logic [8*FRAMES-1:0]  w_pkt_next;

    assign w_fall = ps2clk_prev_q & ~w_ps2clk;

    always_comb begin
        state_d     = state_q;
        bit_idx_d   = bit_idx_q;
        byte_d      = byte_q;
        parity_d    = parity_q;
        fidx_d      = fidx_q;
        pkt_d       = pkt_q;
        to_cnt_d    = to_cnt_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = 1'b0;
        timeout_d   = 1'b0;
        overrun_d   = 1'b0;
        w_good      = 1'b0;
        w_complete  = 1'b0;
        w_pkt_next  = pkt_q;

        // A falling edge always wins over a coincident timeout.
        if (w_fall) begin
            to_cnt_d = '0;
            case (state_q)
                IDLE: begin
                    if (!w_ps2dat) begin
                        state_d   = SHIFT;
                        bit_idx_d = BIT_DATA_LSB;
                    end else begin
                        frame_err_d = 1'b1;
                        fidx_d      = '0;
                    end
                end
                default: begin
                    if (bit_idx_q == BIT_STOP) begin
                        state_d   = IDLE;
                        bit_idx_d = BIT_START;
                        w_good    = w_ps2dat
                                  && ((CHECK_PARITY == 0) || (^{byte_q, parity_q}))
                                  && !((ALIGN_BIT3 != 0) && (fidx_q == '0) && !byte_q[3]);
                        if (w_good) begin
                            for (int k = 0; k < FRAMES; k++) begin
                                if (fidx_q == FIDX_W'(k)) begin
                                    w_pkt_next[8*k +: 8] = byte_q;
                                end
                            end
                            pkt_d = w_pkt_next;
                            if (fidx_q == LAST_FRAME) begin
                                fidx_d     = '0;
                                w_complete = 1'b1;
                            end else begin
                                fidx_d = fidx_q + 1'b1;
                            end
                        end else begin
                            frame_err_d = 1'b1;
                            fidx_d      = '0;
                        end
                    end else begin
                        if (bit_idx_q == BIT_PARITY) begin
                            parity_d = w_ps2dat;
                        end else begin
                            byte_d = {w_ps2dat, byte_q[7:1]};
                        end
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end
            endcase
        end else if ((state_q == IDLE) && (fidx_q == '0)) begin
            to_cnt_d = '0;
        end else if (to_cnt_q == TO_LIMIT) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
            bit_idx_d = BIT_START;
            fidx_d    = '0;
            to_cnt_d  = '0;
        end else begin
            to_cnt_d = to_cnt_q + 1'b1;
        end

        if (w_complete) begin
            if (!valid_q || i_ready) begin
                data_d  = w_pkt_next;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q       <= IDLE;
            bit_idx_q     <= BIT_START;
            byte_q        <= '0;
            parity_q      <= 1'b0;
            fidx_q        <= '0;
            pkt_q         <= '0;
            to_cnt_q      <= '0;
            data_q        <= '0;
            valid_q       <= 1'b0;
            frame_err_q   <= 1'b0;
            timeout_q     <= 1'b0;
            overrun_q     <= 1'b0;
            ps2clk_prev_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            bit_idx_q     <= bit_idx_d;
            byte_q        <= byte_d;
            parity_q      <= parity_d;
            fidx_q        <= fidx_d;
            pkt_q         <= pkt_d;
            to_cnt_q      <= to_cnt_d;
            data_q        <= data_d;
            valid_q       <= valid_d;
            frame_err_q   <= frame_err_d;
            timeout_q     <= timeout_d;
            overrun_q     <= overrun_d;
            ps2clk_prev_q <= w_ps2clk;
        end
    end

    assign o_data      = data_q;
    assign o_valid     = valid_q;
    assign o_frame_err = frame_err_q;
    assign o_timeout   = timeout_q;
    assign o_overrun   = overrun_q;

endmodule : ps2_packet_rx
`default_nettype wire

// File: tb/tb_ps2_packet_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_packet_rx
// Purpose  : Scoreboard bench for the PS/2 packet receiver (3-byte packets).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_packet_rx;

    localparam int FRAMES         = 3;
    localparam int FILTER_LEN     = 8;
    localparam int TIMEOUT_CYCLES = 2000;
    localparam int HALF           = 20;
    localparam int EDGE_LATENCY   = 11;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset_n;
    logic                 ps2c;
    logic                 ps2d;
    logic                 ready;
    logic [8*FRAMES-1:0]  data;
    logic                 valid;
    logic                 ferr;
    logic                 tout;
    logic                 ovr;

    ps2_packet_rx #(
        .FRAMES         (FRAMES),
        .FILTER_LEN     (FILTER_LEN),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CHECK_PARITY   (1),
        .ALIGN_BIT3     (1)
    ) dut (
        .i_clk       (clk),
        .i_reset_n   (reset_n),
        .i_PS2Clk    (ps2c),
        .i_PS2Data   (ps2d),
        .o_data      (data),
        .o_valid     (valid),
        .i_ready     (ready),
        .o_frame_err (ferr),
        .o_timeout   (tout),
        .o_overrun   (ovr)
    );

    int n_cmp = 0;
    int n_err = 0;
    logic [8*FRAMES-1:0] exp_q[$];
    logic [8*FRAMES-1:0] mon_exp;
    int cyc = 0;
    int last_fall = 0;
    int rise_cyc = 0;
    int ferr_cnt = 0;
    int tout_cnt = 0;
    int ovr_cnt = 0;
    int vld_cnt = 0;
    logic valid_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: pulse counters and scoreboard pop on each transfer.
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (ferr === 1'b1) ferr_cnt++;
            if (tout === 1'b1) tout_cnt++;
            if (ovr === 1'b1) ovr_cnt++;
            if (valid === 1'b1) vld_cnt++;
            if (valid === 1'b1 && valid_prev !== 1'b1) rise_cyc = cyc;
            if (valid === 1'b1 && ready === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_packet: got %h, none expected", data);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (data !== mon_exp) begin
                        n_err++;
                        $display("FAIL packet_data: got %h, expected %h", data, mon_exp);
                    end
                end
            end
        end
        valid_prev = valid;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_counts();
        ferr_cnt = 0;
        tout_cnt = 0;
        ovr_cnt  = 0;
        vld_cnt  = 0;
    endtask

    task automatic send_bit(input logic v, input bit glitch);
        ps2d = v;
        if (glitch) begin
            tick(5);
            ps2c = 1'b0;
            tick(3);
            ps2c = 1'b1;
            tick(HALF - 8);
        end else begin
            tick(HALF);
        end
        ps2c = 1'b0;
        last_fall = cyc;
        tick(HALF);
        ps2c = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit flip_par, input bit glitch);
        logic par;
        par = (~^b) ^ flip_par;
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], glitch && (i == 2 || i == 5));
        send_bit(par, glitch);
        send_bit(1'b1, 1'b0);
        ps2d = 1'b1;
        tick(HALF);
    endtask

    task automatic send_packet(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        send_frame(b0, 1'b0, 1'b0);
        send_frame(b1, 1'b0, 1'b0);
        send_frame(b2, 1'b0, 1'b0);
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) tick(1);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL %s_drain: %0d packets outstanding, expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        ps2c = 1'b1;
        ps2d = 1'b1;
        ready = 1'b1;
        tick(5);
        n_cmp++;
        if (data !== '0) begin
            n_err++; $display("FAIL reset_data: got %h, expected 0", data);
        end
        n_cmp++;
        if ({valid, ferr, tout, ovr} !== 4'b0000) begin
            n_err++; $display("FAIL reset_flags: got %b, expected 0000", {valid, ferr, tout, ovr});
        end
        reset_n = 1'b1;
        clear_counts();
        tick(30);
        n_cmp++;
        if (ferr_cnt + tout_cnt + ovr_cnt + vld_cnt !== 0) begin
            n_err++; $display("FAIL reset_idle_events: got %0d, expected 0", ferr_cnt + tout_cnt + ovr_cnt + vld_cnt);
        end
    endtask

    task automatic test_basic();
        clear_counts();
        exp_q.push_back(24'h341208);
        send_packet(8'h08, 8'h12, 8'h34);
        wait_drain("basic");
        n_cmp++;
        if (rise_cyc - last_fall !== EDGE_LATENCY) begin
            n_err++; $display("FAIL basic_latency: got %0d cycles, expected %0d", rise_cyc - last_fall, EDGE_LATENCY);
        end
        n_cmp++;
        if (vld_cnt !== 1) begin
            n_err++; $display("FAIL basic_valid_cycles: got %0d, expected 1", vld_cnt);
        end
        n_cmp++;
        if (ferr_cnt !== 0) begin
            n_err++; $display("FAIL basic_frame_err: got %0d, expected 0", ferr_cnt);
        end
    endtask

    task automatic test_parity();
        clear_counts();
        send_frame(8'h08, 1'b0, 1'b0);
        send_frame(8'h12, 1'b1, 1'b0);
        tick(10);
        n_cmp++;
        if (ferr_cnt !== 1 || vld_cnt !== 0) begin
            n_err++; $display("FAIL parity_err: got err=%0d valid=%0d, expected err=1 valid=0", ferr_cnt, vld_cnt);
        end
        exp_q.push_back(24'h341208);
        send_packet(8'h08, 8'h12, 8'h34);
        wait_drain("parity_recover");
    endtask

    task automatic test_align();
        clear_counts();
        send_frame(8'h00, 1'b0, 1'b0);
        tick(10);
        n_cmp++;
        if (ferr_cnt !== 1 || vld_cnt !== 0) begin
            n_err++; $display("FAIL align_err: got err=%0d valid=%0d, expected err=1 valid=0", ferr_cnt, vld_cnt);
        end
        exp_q.push_back(24'h55AA08);
        send_packet(8'h08, 8'hAA, 8'h55);
        wait_drain("align_recover");
    endtask

    task automatic test_timeout();
        clear_counts();
        send_frame(8'h08, 1'b0, 1'b0);
        send_frame(8'h12, 1'b0, 1'b0);
        tick(TIMEOUT_CYCLES + 10);
        n_cmp++;
        if (tout_cnt !== 1 || vld_cnt !== 0) begin
            n_err++; $display("FAIL timeout_pulse: got tout=%0d valid=%0d, expected tout=1 valid=0", tout_cnt, vld_cnt);
        end
        exp_q.push_back(24'hCDAB08);
        send_packet(8'h08, 8'hAB, 8'hCD);
        wait_drain("timeout_recover");
        n_cmp++;
        if (ferr_cnt !== 0 || tout_cnt !== 1) begin
            n_err++; $display("FAIL timeout_after: got err=%0d tout=%0d, expected err=0 tout=1", ferr_cnt, tout_cnt);
        end
    endtask

    task automatic test_overrun();
        clear_counts();
        ready = 1'b0;
        exp_q.push_back(24'h221108);
        send_packet(8'h08, 8'h11, 8'h22);
        tick(5);
        n_cmp++;
        if (valid !== 1'b1 || data !== 24'h221108) begin
            n_err++; $display("FAIL overrun_first: got valid=%b data=%h, expected 1/221108", valid, data);
        end
        send_packet(8'h09, 8'h33, 8'h44);
        tick(5);
        n_cmp++;
        if (valid !== 1'b1 || data !== 24'h221108) begin
            n_err++; $display("FAIL overrun_hold: got valid=%b data=%h, expected 1/221108", valid, data);
        end
        n_cmp++;
        if (ovr_cnt !== 1) begin
            n_err++; $display("FAIL overrun_pulse: got %0d, expected 1", ovr_cnt);
        end
        ready = 1'b1;
        tick(1);
        ready = 1'b0;
        n_cmp++;
        if (valid !== 1'b0 || data !== 24'h221108) begin
            n_err++; $display("FAIL overrun_release: got valid=%b data=%h, expected 0/221108", valid, data);
        end
        wait_drain("overrun");
        ready = 1'b1;
    endtask

    task automatic test_glitch();
        clear_counts();
        exp_q.push_back(24'hC35A08);
        send_frame(8'h08, 1'b0, 1'b1);
        send_frame(8'h5A, 1'b0, 1'b1);
        send_frame(8'hC3, 1'b0, 1'b1);
        wait_drain("glitch");
        n_cmp++;
        if (ferr_cnt !== 0 || vld_cnt !== 1) begin
            n_err++; $display("FAIL glitch_events: got err=%0d valid=%0d, expected 0/1", ferr_cnt, vld_cnt);
        end
    endtask

    task automatic test_reset_midframe();
        clear_counts();
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
        reset_n = 1'b0;
        tick(3);
        reset_n = 1'b1;
        tick(20);
        exp_q.push_back(24'h667708);
        send_packet(8'h08, 8'h77, 8'h66);
        wait_drain("reset_midframe");
        n_cmp++;
        if (ferr_cnt !== 0) begin
            n_err++; $display("FAIL reset_midframe_err: got %0d, expected 0", ferr_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_parity();
        test_align();
        test_timeout();
        test_overrun();
        test_glitch();
        test_reset_midframe();
        tick(10);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_ps2_packet_rx
`default_nettype wire
